// File: rtl/card_reader_check.sv
// Card-reader front end: deserialises a bit-serial card ID, checks it against a
// programmable table of authorised IDs, and grants, rejects or locks out.
module card_reader_check #(
    parameter int ID_WIDTH       = 16,
    parameter int NUM_IDS        = 4,
    parameter int BIT_TIMEOUT    = 255,
    parameter int VALID_HOLD     = 16,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_start,
    input  logic                         rx_bit,
    input  logic                         rx_strobe,
    input  logic                         prog_we,
    input  logic [$clog2(NUM_IDS)-1:0]   prog_idx,
    input  logic [ID_WIDTH-1:0]          prog_id,
    input  logic                         prog_en,
    output logic                         card_valid,
    output logic                         card_reject,
    output logic                         lockout,
    output logic                         busy
);

    localparam int IDX_W  = $clog2(NUM_IDS);
    localparam int CNT_W  = $clog2(ID_WIDTH + 1);
    localparam int GAP_W  = $clog2(BIT_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(VALID_HOLD + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECEIVE,
        S_COMPARE,
        S_GRANT,
        S_DENY,
        S_LOCKED
    } state_t;

    state_t              state_reg, state_next;
    logic [ID_WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [GAP_W-1:0]    gap_reg, gap_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic [LOCK_W-1:0]   lock_reg, lock_next;
    logic [FAIL_W-1:0]   fail_reg, fail_next;
    logic [FAIL_W-1:0]   fail_inc;
    logic                card_valid_reg, card_reject_reg, lockout_reg, busy_reg;
    logic [NUM_IDS-1:0]  hit;
    logic                match;

    // Authorised-ID table: each entry is its own register pair so an entry
    // can be rewritten while another is being compared.
    generate
        for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_entry
            logic [ID_WIDTH-1:0] id_reg;
            logic                en_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    id_reg <= '0;
                    en_reg <= 1'b0;
                end else if (prog_we && (prog_idx == IDX_W'(gi))) begin
                    id_reg <= prog_id;
                    en_reg <= prog_en;
                end
            end

            assign hit[gi] = en_reg && (id_reg == shift_reg);
        end
    endgenerate

    assign match = |hit;

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_next     = gap_reg;
        hold_next    = hold_reg;
        lock_next    = lock_reg;
        fail_next    = fail_reg;
        fail_inc     = (fail_reg == FAIL_W'(MAX_FAILS)) ? fail_reg : fail_reg + 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (rx_start) begin
                    state_next   = S_RECEIVE;
                    shift_next   = '0;
                    bit_cnt_next = '0;
                    gap_next     = '0;
                end
            end
            S_RECEIVE: begin
                // A restart wins over a coincident strobe, which is dropped.
                if (rx_start) begin
                    shift_next   = '0;
                    bit_cnt_next = '0;
                    gap_next     = '0;
                end else if (rx_strobe) begin
                    shift_next   = {shift_reg[ID_WIDTH-2:0], rx_bit};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    gap_next     = '0;
                    if (bit_cnt_reg == CNT_W'(ID_WIDTH - 1)) begin
                        state_next = S_COMPARE;
                    end
                end else begin
                    gap_next = gap_reg + 1'b1;
                    if (gap_reg == GAP_W'(BIT_TIMEOUT - 1)) begin
                        state_next = S_DENY;
                    end
                end
            end
            S_COMPARE: begin
                if (match) begin
                    state_next = S_GRANT;
                    hold_next  = '0;
                    fail_next  = '0;
                end else begin
                    state_next = S_DENY;
                end
            end
            S_GRANT: begin
                if (hold_reg == HOLD_W'(VALID_HOLD - 1)) begin
                    state_next = S_IDLE;
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            S_DENY: begin
                fail_next = fail_inc;
                if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                    state_next = S_LOCKED;
                    lock_next  = '0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (lock_reg == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                    state_next = S_IDLE;
                    fail_next  = '0;
                end else begin
                    lock_next = lock_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            gap_reg         <= '0;
            hold_reg        <= '0;
            lock_reg        <= '0;
            fail_reg        <= '0;
            card_valid_reg  <= 1'b0;
            card_reject_reg <= 1'b0;
            lockout_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            gap_reg         <= gap_next;
            hold_reg        <= hold_next;
            lock_reg        <= lock_next;
            fail_reg        <= fail_next;
            // Status outputs trail the state by one cycle; busy tracks the
            // upcoming state so it rises on the edge that accepts rx_start.
            card_valid_reg  <= (state_reg == S_GRANT);
            card_reject_reg <= (state_reg == S_DENY);
            lockout_reg     <= (state_reg == S_LOCKED);
            busy_reg        <= (state_next != S_IDLE);
        end
    end

    assign card_valid  = card_valid_reg;
    assign card_reject = card_reject_reg;
    assign lockout     = lockout_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_card_reader_check.sv
// Self-checking bench for card_reader_check: frame-level reference model with
// expected output waveforms derived from the grant/reject/lockout timing rules.
module tb_card_reader_check;

    localparam int VH = 16;
    localparam int L  = 1024;
    localparam int BT = 255;
    localparam int MF = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_start, rx_bit, rx_strobe;
    logic        prog_we, prog_en;
    logic [1:0]  prog_idx;
    logic [15:0] prog_id;
    logic        card_valid, card_reject, lockout, busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_id [4];
    bit          m_en [4];
    int          m_fail;

    always #5 clk = ~clk;

    card_reader_check #(
        .ID_WIDTH(16), .NUM_IDS(4), .BIT_TIMEOUT(BT), .VALID_HOLD(VH),
        .MAX_FAILS(MF), .LOCKOUT_CYCLES(L)
    ) dut (
        .clk(clk), .reset(reset), .rx_start(rx_start), .rx_bit(rx_bit),
        .rx_strobe(rx_strobe), .prog_we(prog_we), .prog_idx(prog_idx),
        .prog_id(prog_id), .prog_en(prog_en), .card_valid(card_valid),
        .card_reject(card_reject), .lockout(lockout), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int i = 0; i < 4; i++) begin
            m_id[i] = '0;
            m_en[i] = 1'b0;
        end
        m_fail = 0;
    endtask

    function automatic bit model_match(input logic [15:0] id);
        for (int i = 0; i < 4; i++) begin
            if (m_en[i] && m_id[i] == id) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic prog(input int idx, input logic [15:0] id, input bit en);
        prog_we  = 1'b1;
        prog_idx = idx[1:0];
        prog_id  = id;
        prog_en  = en;
        tick;
        prog_we  = 1'b0;
        m_id[idx] = id;
        m_en[idx] = en;
    endtask

    // rx_start pulse (optionally with a coincident strobe), then nbits strobes
    // spaced gap cycles apart; returns just after the edge sampling the last strobe.
    task automatic send_frame(input logic [15:0] id, input int nbits, input int gap,
                              input bit coincide, input string name);
        rx_start  = 1'b1;
        rx_strobe = coincide;
        rx_bit    = 1'b1;
        tick;
        rx_start  = 1'b0;
        rx_strobe = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end
        for (int b = 0; b < nbits; b++) begin
            repeat (gap - 1) tick;
            rx_strobe = 1'b1;
            rx_bit    = id[15 - b];
            tick;
            rx_strobe = 1'b0;
        end
    endtask

    // Checks {card_valid, card_reject, lockout, busy} every cycle after the
    // deciding edge. off shifts the reject point (BT-1 for a timeout).
    task automatic observe(input logic [15:0] id, input bit timed_out, input int tail,
                           input bit inject, input string name);
        bit          grant, lock;
        int          off, endk;
        logic [3:0]  exp_v, got_v;
        logic [15:0] inj;
        inj   = 16'hA5C3;
        grant = !timed_out && model_match(id);
        off   = timed_out ? BT - 1 : 0;
        if (grant) m_fail = 0;
        else if (m_fail < MF) m_fail++;
        lock = !grant && (m_fail == MF);
        endk = grant ? 1 + VH : (lock ? off + 2 + L : off + 2);
        $display("txn %s id=%h timeout=%0b grant=%0b lock=%0b", name, id, timed_out, grant, lock);
        for (int k = 1; k <= endk + tail; k++) begin
            tick;
            prog_we   = 1'b0;
            rx_start  = 1'b0;
            rx_strobe = 1'b0;
            if (inject && lock) begin
                if (k == off + 10) rx_start = 1'b1;
                if (k > off + 10 && k <= off + 26) begin
                    rx_strobe = 1'b1;
                    rx_bit    = inj[15 - (k - off - 11)];
                end
            end
            exp_v[3] = grant && k >= off + 2 && k < off + 2 + VH;
            exp_v[2] = !grant && k == off + 2;
            exp_v[1] = lock && k >= off + 3 && k < off + 3 + L;
            exp_v[0] = k < (grant ? 1 + VH : (lock ? off + 2 + L : off + 2));
            got_v    = {card_valid, card_reject, lockout, busy};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s k=%0d {valid,reject,lockout,busy}: got %b expected %b",
                         name, k, got_v, exp_v);
            end
        end
        if (lock) m_fail = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        checks++;
        if ({card_valid, card_reject, lockout, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold outputs: got %b expected 0000",
                     {card_valid, card_reject, lockout, busy});
        end
        reset = 1'b0;
        tick;
        checks++;
        if ({card_valid, card_reject, lockout, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release outputs: got %b expected 0000",
                     {card_valid, card_reject, lockout, busy});
        end
        clear_model;
    endtask

    task automatic test_grant;
        prog(0, 16'hA5C3, 1'b1);
        send_frame(16'hA5C3, 16, 3, 1'b0, "grant");
        observe(16'hA5C3, 1'b0, 3, 1'b0, "grant");
    endtask

    task automatic test_lockout;
        for (int n = 0; n < 3; n++) begin
            send_frame(16'h1234, 16, 2, 1'b0, "lockout");
            observe(16'h1234, 1'b0, 3, (n == 2), "lockout");
        end
        send_frame(16'hA5C3, 16, 2, 1'b0, "after_lock");
        observe(16'hA5C3, 1'b0, 3, 1'b0, "after_lock");
    endtask

    task automatic test_timeout;
        send_frame(16'hFFFF, 7, 3, 1'b0, "timeout");
        observe(16'hFFFF, 1'b1, 3, 1'b0, "timeout");
        send_frame(16'hA5C3, 16, 1, 1'b0, "post_timeout");
        observe(16'hA5C3, 1'b0, 3, 1'b0, "post_timeout");
    endtask

    task automatic test_prog_enable;
        prog(2, 16'hBEEF, 1'b0);
        send_frame(16'hBEEF, 16, 2, 1'b0, "disabled");
        // Write lands on the compare edge, so the old (disabled) entry decides.
        prog_we  = 1'b1;
        prog_idx = 2'd2;
        prog_id  = 16'hBEEF;
        prog_en  = 1'b1;
        observe(16'hBEEF, 1'b0, 3, 1'b0, "disabled");
        m_id[2] = 16'hBEEF;
        m_en[2] = 1'b1;
        send_frame(16'hBEEF, 16, 2, 1'b0, "enabled");
        observe(16'hBEEF, 1'b0, 3, 1'b0, "enabled");
    endtask

    task automatic test_restart;
        send_frame(16'h0000, 8, 2, 1'b0, "restart_part");
        send_frame(16'hA5C3, 16, 2, 1'b1, "restart");
        observe(16'hA5C3, 1'b0, 3, 1'b0, "restart");
    endtask

    task automatic test_back_to_back;
        send_frame(16'hA5C3, 16, 1, 1'b0, "b2b_grant");
        observe(16'hA5C3, 1'b0, 0, 1'b0, "b2b_grant");
        send_frame(16'h1234, 16, 1, 1'b0, "b2b_reject");
        observe(16'h1234, 1'b0, 0, 1'b0, "b2b_reject");
        send_frame(16'hA5C3, 16, 1, 1'b0, "b2b_regrant");
        observe(16'hA5C3, 1'b0, 3, 1'b0, "b2b_regrant");
    endtask

    task automatic test_random;
        logic [15:0] id;
        int          gap;
        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 2) == 0)
                prog(int'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) id = m_id[$urandom_range(0, 3)];
            else id = 16'($urandom);
            gap = int'($urandom_range(1, 4));
            send_frame(id, 16, gap, 1'b0, "random");
            observe(id, 1'b0, 3, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_grant;
        prog(0, 16'hA5C3, 1'b1);
        send_frame(16'hA5C3, 16, 2, 1'b0, "mid_grant");
        repeat (6) tick;
        checks++;
        if (card_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant valid_before_reset: got %b expected 1", card_valid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({card_valid, card_reject, lockout, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_grant async_reset outputs: got %b expected 0000",
                     {card_valid, card_reject, lockout, busy});
        end
        tick;
        reset = 1'b0;
        tick;
        clear_model;
        send_frame(16'hA5C3, 16, 2, 1'b0, "cleared_table");
        observe(16'hA5C3, 1'b0, 3, 1'b0, "cleared_table");
    endtask

    initial begin
        reset     = 1'b1;
        rx_start  = 1'b0;
        rx_bit    = 1'b0;
        rx_strobe = 1'b0;
        prog_we   = 1'b0;
        prog_en   = 1'b0;
        prog_idx  = '0;
        prog_id   = '0;
        test_reset;
        test_grant;
        test_lockout;
        test_timeout;
        test_prog_enable;
        test_restart;
        test_back_to_back;
        test_random;
        test_reset_mid_grant;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_reader_check.md
# card_reader_check

Card-reader front end that feeds `card_valid` to the door controller. It deserialises a bit-serial card ID from the reader and compares it against a small programmable table of authorised IDs. It then either holds `card_valid` high for a fixed window or emits a reject pulse. Repeated rejects trigger a timed lockout so that IDs cannot be brute-forced.

## Interface
Parameters:
- `ID_WIDTH`, 16: card ID length in bits.
- `NUM_IDS`, 4: number of authorised-ID table entries.
- `BIT_TIMEOUT`, 255: maximum number of cycles allowed between frame start or last strobe and the next strobe.
- `VALID_HOLD`, 16: number of cycles `card_valid` stays high after a match.
- `MAX_FAILS`, 3: number of consecutive rejects that triggers lockout.
- `LOCKOUT_CYCLES`, 1024: lockout duration in cycles.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rx_start`  in  1  frame start from the reader (one-cycle pulse).
- `rx_bit`  in  1  serial data bit, MSB first, qualified by `rx_strobe`.
- `rx_strobe`  in  1  `rx_bit` is valid this cycle.
- `prog_we`  in  1  table write enable.
- `prog_idx`  in  $clog2(NUM_IDS)  table entry index.
- `prog_id`  in  ID_WIDTH  ID to store.
- `prog_en`  in  1  entry-enable flag stored with the ID.
- `card_valid`  out  1  authorised card; level held for VALID_HOLD cycles.
- `card_reject`  out  1  one-cycle pulse per rejected or timed-out frame.
- `lockout`  out  1  high while in the lockout state.
- `busy`  out  1  high in any state other than IDLE.

Clock is `clk`. Reset is `reset`, asynchronous and active-high.

## Operation
- Reset:
  - state goes to IDLE;
  - all table enable flags clear, so no ID matches;
  - shift register, bit counter, gap timer and fail counter clear;
  - all outputs are 0.
- Table writes:
  - On `prog_we`, `prog_idx` is written with {`prog_en`, `prog_id`}. Writes are accepted in every state.
  - A write takes effect the following cycle.
  - A compare performed in the same cycle as a write uses the old contents.
  - Out-of-range `prog_idx` (when NUM_IDS is not a power of 2) is ignored.
- States:
  - IDLE: `rx_start` moves to RECEIVE, clearing the bit counter, gap timer and shift register. `rx_strobe` is ignored.
  - RECEIVE:
    - Each `rx_strobe` shifts `rx_bit` into the LSB and increments the count.
    - The gap timer resets on each strobe and otherwise increments.
    - When the count reaches ID_WIDTH, go to COMPARE.
    - When the gap timer reaches BIT_TIMEOUT, go to DENY.
    - `rx_start` restarts the frame (count, timer and shift register cleared, no failure counted). It has priority over a same-cycle strobe, which is discarded.
  - COMPARE (1 cycle):
    - Match means some entry has its enable flag set and its ID equals the shift register.
    - On a match, go to GRANT and clear the fail counter. Otherwise go to DENY.
  - GRANT: `card_valid`=1 for exactly VALID_HOLD cycles, then IDLE.
  - DENY (1 cycle):
    - `card_reject`=1 and the fail counter increments.
    - If the new count equals MAX_FAILS, go to LOCKED. Otherwise go to IDLE.
  - LOCKED: `lockout`=1 for LOCKOUT_CYCLES cycles, then IDLE with the fail counter cleared.
- `rx_start` and strobes are ignored in COMPARE, GRANT, DENY and LOCKED.
- Fail counter saturates at MAX_FAILS. Only a match or the end of a lockout clears it.
- Counter widths are $clog2 of (parameter+1); no counter wraps.

## Timing
- All outputs come directly from flops, with no combinational paths from inputs.
- Grant latency: final strobe sampled at edge N gives COMPARE during cycle N..N+1, and `card_valid` rises at edge N+2. It falls at edge N+2+VALID_HOLD.
- Reject latency: a final strobe at edge N with a mismatch gives `card_reject` high from N+2 to N+3.
- Timeout: the gap timer reaching BIT_TIMEOUT at edge T gives `card_reject` high from T+1 to T+2.
- `lockout` rises in the cycle after the MAX_FAILS-th reject pulse ends and lasts LOCKOUT_CYCLES cycles.
- `busy` rises at the edge after `rx_start` and falls on the return to IDLE.
- The earliest accepted `rx_start` after GRANT, DENY or LOCKED is in the first IDLE cycle.
- Reset mid-operation (any state) forces IDLE and all outputs to 0 immediately, asynchronously. The table is cleared.

## Test plan
- Program idx0 = 16'hA5C3 with en=1, then send A5C3 MSB first with strobes every 3 cycles. `card_valid` rises 2 cycles after the last strobe and stays high 16 cycles; `card_reject` stays 0.
- Send 16'h1234 three times. This produces three 1-cycle `card_reject` pulses, then `lockout`=1 for 1024 cycles. A valid A5C3 frame sent during lockout gives no `card_valid`. After lockout, A5C3 is granted.
- Send 7 bits, then no strobes. `card_reject` pulses 256 cycles after the 7th strobe and the fail counter is 1. A following valid frame grants and clears the counter.
- Program idx2 = 16'hBEEF with en=0 and send BEEF, which is rejected. Rewrite idx2 with en=1 and resend BEEF, which is granted.
- Send 8 bits of 16'h0000, then `rx_start` coincident with a strobe, then a full A5C3. Expect a grant with no reject; the coincident strobe is discarded.
- Assert `reset` mid-GRANT (cycle 5 of 16). `card_valid` drops immediately. A following A5C3 frame is rejected because the table was cleared.
